// File: rtl/cdt_grf_writer_pkg.sv
// Shared register-file constants and the write-enable qualification rule
// used by the conditional write-back path (cdt_grf_writer).
package cdt_grf_writer_pkg;

    localparam int                REG_AW   = 5;
    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;
    localparam int                GRF_NUM  = 32;

    // A conditional write (movz/bgezal) only counts when its resolved enable is set; $0 is never written.
    function automatic logic qualify_we(input logic              valid,
                                        input logic              we,
                                        input logic              cdt,
                                        input logic              cdt_we,
                                        input logic [REG_AW-1:0] wa);
        return valid & we & (~cdt | cdt_we) & (wa != ZERO_REG);
    endfunction

endpackage

// File: rtl/cdt_grf_writer_if.sv
// E-stage write request, M-stage control/load data and D-stage read ports
// of the conditional write-back path.
interface cdt_grf_writer_if
    import cdt_grf_writer_pkg::*;
#(
    parameter int DW = 32
);
    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [REG_AW-1:0] ex_wa;
    logic [DW-1:0]     ex_wd;
    logic              ex_wd_rdy;
    logic              ex_we;
    logic              ex_cdt;
    logic              ex_cdt_we;
    logic              ex_bubble;
    logic              m_kill;
    logic [DW-1:0]     mem_rdata;
    logic [REG_AW-1:0] rs_a;
    logic [REG_AW-1:0] rt_a;
    logic [DW-1:0]     rs_d;
    logic [DW-1:0]     rt_d;
    logic              fwd_stall;

    modport master (
        output ex_valid, ex_pc, ex_wa, ex_wd, ex_wd_rdy, ex_we, ex_cdt, ex_cdt_we,
        output ex_bubble, m_kill, mem_rdata, rs_a, rt_a,
        input  rs_d, rt_d, fwd_stall
    );

    modport slave (
        input  ex_valid, ex_pc, ex_wa, ex_wd, ex_wd_rdy, ex_we, ex_cdt, ex_cdt_we,
        input  ex_bubble, m_kill, mem_rdata, rs_a, rt_a,
        output rs_d, rt_d, fwd_stall
    );

endinterface

// File: rtl/cdt_grf_writer_grf_core.sv
// General register file: NREG x DW array, async active-low reset, one write
// port, two read ports with write-through so a W-stage write is visible at once.
module grf_core
    import cdt_grf_writer_pkg::*;
#(
    parameter int NREG = GRF_NUM,
    parameter int DW   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DW-1:0]     wd,
    input  logic [REG_AW-1:0] ra0,
    input  logic [REG_AW-1:0] ra1,
    output logic [DW-1:0]     rd0,
    output logic [DW-1:0]     rd1
);

    logic [DW-1:0] mem [NREG];
    logic          wr_ok;

    assign wr_ok = we & (wa != ZERO_REG);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[wa] <= wd;
        end
    end

    assign rd0 = (wr_ok && ra0 == wa) ? wd : mem[ra0];
    assign rd1 = (wr_ok && ra1 == wa) ? wd : mem[ra1];

endmodule

// File: rtl/cdt_grf_writer.sv
// Conditional write-back path: E->M->W registers, M forwarding, load-use stall.
// Define GRF_WB_LOG_EN to print a line for every committed register write.
module cdt_grf_writer
    import cdt_grf_writer_pkg::*;
#(
    parameter int NREG = GRF_NUM,
    parameter int DW   = 32
) (
    input logic             clk,
    input logic             reset,
    cdt_grf_writer_if.slave bus
);

    logic              eff_we_p0;
    logic              vld_p1, vld_p2;
    logic              rdy_p1;
    logic [REG_AW-1:0] wa_p1, wa_p2;
    logic [DW-1:0]     wd_p1, wd_p2;
    logic [DW-1:0]     core_rs, core_rt;
    logic              rs_hit_m, rt_hit_m;
    logic              rs_wait, rt_wait;

    assign eff_we_p0 = qualify_we(bus.ex_valid, bus.ex_we, bus.ex_cdt, bus.ex_cdt_we, bus.ex_wa);

    // E->M and M->W control: bubble clears the M capture, kill clears the W capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            rdy_p1 <= 1'b1;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= eff_we_p0 & ~bus.ex_bubble;
            rdy_p1 <= bus.ex_wd_rdy;
            vld_p2 <= vld_p1 & ~bus.m_kill;
        end
    end

    // Data follows its valid; load data is merged in on the M->W edge
    always_ff @(posedge clk) begin
        wa_p1 <= bus.ex_wa;
        wd_p1 <= bus.ex_wd;
        wa_p2 <= wa_p1;
        wd_p2 <= rdy_p1 ? wd_p1 : bus.mem_rdata;
    end

    grf_core #(.NREG(NREG), .DW(DW)) u_core (
        .clk   (clk),
        .reset (reset),
        .we    (vld_p2),
        .wa    (wa_p2),
        .wd    (wd_p2),
        .ra0   (bus.rs_a),
        .ra1   (bus.rt_a),
        .rd0   (core_rs),
        .rd1   (core_rt)
    );

    // M is younger than W, so an M hit overrides the core's W bypass
    assign rs_hit_m = vld_p1 & rdy_p1 & (wa_p1 == bus.rs_a);
    assign rt_hit_m = vld_p1 & rdy_p1 & (wa_p1 == bus.rt_a);

    assign bus.rs_d = (bus.rs_a == ZERO_REG) ? '0 : (rs_hit_m ? wd_p1 : core_rs);
    assign bus.rt_d = (bus.rt_a == ZERO_REG) ? '0 : (rt_hit_m ? wd_p1 : core_rt);

    assign rs_wait = (bus.rs_a != ZERO_REG) & vld_p1 & ~rdy_p1 & (wa_p1 == bus.rs_a);
    assign rt_wait = (bus.rt_a != ZERO_REG) & vld_p1 & ~rdy_p1 & (wa_p1 == bus.rt_a);
    assign bus.fwd_stall = rs_wait | rt_wait;

`ifdef GRF_WB_LOG_EN
    // PC is only needed by the commit log
    logic [31:0] pc_p1, pc_p2;

    always_ff @(posedge clk) begin
        pc_p1 <= bus.ex_pc;
        pc_p2 <= pc_p1;
    end

    always_ff @(posedge clk) begin
        if (reset && vld_p2) $display("@%h: $%d <= %h", pc_p2, wa_p2, wd_p2);
    end
`endif

endmodule

// File: tb/tb_cdt_grf_writer.sv
// Bench for cdt_grf_writer: directed scenarios then random traffic, all checked
// against an architectural model holding the register file plus in-flight writes.
module tb_cdt_grf_writer;
    import cdt_grf_writer_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    cdt_grf_writer_if #(.DW(32)) bus ();

    cdt_grf_writer #(.NREG(32), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        eff;
        bit [4:0]  wa;
        bit [31:0] wd;
        bit        rdy;
    } rec_t;

    // flight[0] = write now in M, flight[1] = write now in W
    rec_t      flight [2];
    bit [31:0] arch [32];

    function automatic bit [31:0] exp_rd(input bit [4:0] a);
        if (a == 0) return 32'd0;
        if (flight[0].eff && flight[0].rdy && flight[0].wa == a) return flight[0].wd;
        if (flight[1].eff && flight[1].wa == a) return flight[1].wd;
        return arch[a];
    endfunction

    function automatic bit exp_wait(input bit [4:0] a);
        return (a != 0) && flight[0].eff && !flight[0].rdy && flight[0].wa == a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rec_t z;
        z = '{eff: 1'b0, wa: 5'd0, wd: 32'd0, rdy: 1'b1};
        flight[0] = z;
        flight[1] = z;
        for (int i = 0; i < 32; i++) arch[i] = 32'd0;
    endtask

    task automatic model_edge();
        rec_t w, e;
        if (flight[1].eff) arch[flight[1].wa] = flight[1].wd;
        w = flight[0];
        w.eff = w.eff && !bus.m_kill;
        if (!w.rdy) w.wd = bus.mem_rdata;
        w.rdy = 1'b1;
        e.eff = bus.ex_valid && bus.ex_we && (!bus.ex_cdt || bus.ex_cdt_we) &&
                (bus.ex_wa != 0) && !bus.ex_bubble;
        e.wa  = bus.ex_wa;
        e.wd  = bus.ex_wd;
        e.rdy = bus.ex_wd_rdy;
        flight[0] = e;
        flight[1] = w;
    endtask

    task automatic settle();
        @(negedge clk);
        chk("rs_d", bus.rs_d, exp_rd(bus.rs_a));
        chk("rt_d", bus.rt_d, exp_rd(bus.rt_a));
        chk("fwd_stall", {31'd0, bus.fwd_stall}, {31'd0, exp_wait(bus.rs_a) | exp_wait(bus.rt_a)});
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset) model_edge();
        else model_reset();
        #1;
    endtask

    task automatic idle();
        bus.ex_valid  = 1'b0;
        bus.ex_pc     = 32'd0;
        bus.ex_wa     = 5'd0;
        bus.ex_wd     = 32'd0;
        bus.ex_wd_rdy = 1'b1;
        bus.ex_we     = 1'b0;
        bus.ex_cdt    = 1'b0;
        bus.ex_cdt_we = 1'b0;
        bus.ex_bubble = 1'b0;
        bus.m_kill    = 1'b0;
        bus.mem_rdata = 32'd0;
    endtask

    task automatic wr(input bit [4:0] wa, input bit [31:0] wd, input bit rdy,
                      input bit cdt, input bit cdt_we);
        idle();
        bus.ex_valid  = 1'b1;
        bus.ex_we     = 1'b1;
        bus.ex_pc     = 32'h0040_0000 + {27'd0, wa} * 4;
        bus.ex_wa     = wa;
        bus.ex_wd     = wd;
        bus.ex_wd_rdy = rdy;
        bus.ex_cdt    = cdt;
        bus.ex_cdt_we = cdt_we;
    endtask

    task automatic cyc(); settle(); advance(); endtask

    initial begin
        idle();
        bus.rs_a = 5'd3;
        bus.rt_a = 5'd0;
        model_reset();

        // Reset state
        settle();
        chk("rst_rs", bus.rs_d, 32'd0);
        chk("rst_stall", {31'd0, bus.fwd_stall}, 32'd0);
        advance();
        cyc();
        reset = 1'b1;

        // 1: movz taken -> M forward, W forward, then regfile
        wr(5'd3, 32'd7, 1'b1, 1'b1, 1'b1); cyc();
        idle(); settle(); chk("t1_mfwd", bus.rs_d, 32'd7); advance();
        settle(); chk("t1_wfwd", bus.rs_d, 32'd7); advance();
        settle(); chk("t1_rf", bus.rs_d, 32'd7); advance();

        // 2: $3 <= 5, then movz not taken with wd=9
        wr(5'd3, 32'd5, 1'b1, 1'b0, 1'b0); cyc();
        idle(); repeat (3) cyc();
        wr(5'd3, 32'd9, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            settle(); chk("t2_hold", bus.rs_d, 32'd5); advance(); idle();
        end

        // 3: load to $4, consumer in the next cycle stalls once
        bus.rs_a = 5'd4;
        wr(5'd4, 32'h1111, 1'b0, 1'b0, 1'b0); cyc();
        idle(); bus.mem_rdata = 32'hABCD;
        settle(); chk("t3_stall", {31'd0, bus.fwd_stall}, 32'd1); advance();
        idle();
        settle(); chk("t3_nostall", {31'd0, bus.fwd_stall}, 32'd0);
        chk("t3_wfwd", bus.rs_d, 32'hABCD); advance();
        repeat (2) cyc();
        chk("t3_rf", bus.rs_d, 32'hABCD);

        // 4: $5 <= 1 then $5 <= 2, younger write wins
        bus.rs_a = 5'd5;
        wr(5'd5, 32'd1, 1'b1, 1'b0, 1'b0); cyc();
        wr(5'd5, 32'd2, 1'b1, 1'b0, 1'b0); cyc();
        idle(); settle(); chk("t4_m_over_w", bus.rs_d, 32'd2); advance();
        repeat (3) cyc();
        chk("t4_final", bus.rs_d, 32'd2);

        // 5: kill in M drops $6; bubble at E drops $7; both at once
        bus.rs_a = 5'd6; bus.rt_a = 5'd7;
        wr(5'd6, 32'h55, 1'b1, 1'b0, 1'b0); cyc();
        idle(); bus.m_kill = 1'b1; cyc();
        idle(); repeat (3) cyc();
        chk("t5_kill", bus.rs_d, 32'd0);
        wr(5'd7, 32'h77, 1'b1, 1'b0, 1'b0); bus.ex_bubble = 1'b1; cyc();
        idle(); repeat (3) cyc();
        chk("t5_bubble", bus.rt_d, 32'd0);
        wr(5'd6, 32'h66, 1'b1, 1'b0, 1'b0); cyc();
        wr(5'd7, 32'h88, 1'b1, 1'b0, 1'b0); bus.ex_bubble = 1'b1; bus.m_kill = 1'b1; cyc();
        idle(); repeat (3) cyc();
        chk("t5_both_rs", bus.rs_d, 32'd0);
        chk("t5_both_rt", bus.rt_d, 32'd0);

        // 6: async reset with writes in M and W
        bus.rs_a = 5'd10; bus.rt_a = 5'd11;
        wr(5'd10, 32'hA0, 1'b1, 1'b0, 1'b0); cyc();
        wr(5'd11, 32'hB0, 1'b1, 1'b0, 1'b0); cyc();
        idle();
        reset = 1'b0;
        #1;
        chk("t6_rs_now", bus.rs_d, 32'd0);
        chk("t6_rt_now", bus.rt_d, 32'd0);
        chk("t6_stall_now", {31'd0, bus.fwd_stall}, 32'd0);
        model_reset();
        cyc(); cyc();
        reset = 1'b1;
        repeat (4) cyc();
        chk("t6_rs_after", bus.rs_d, 32'd0);
        chk("t6_rt_after", bus.rt_d, 32'd0);
        bus.rs_a = 5'd3;
        #1;
        chk("t6_old_reg", bus.rs_d, 32'd0);

        // Random traffic over a small register window to force collisions
        for (int i = 0; i < 600; i++) begin
            bus.ex_valid  = ($urandom_range(0, 3) != 0);
            bus.ex_we     = ($urandom_range(0, 3) != 0);
            bus.ex_pc     = $urandom;
            bus.ex_wa     = 5'($urandom_range(0, 7));
            bus.ex_wd     = $urandom;
            bus.ex_wd_rdy = ($urandom_range(0, 3) != 0);
            bus.ex_cdt    = ($urandom_range(0, 2) == 0);
            bus.ex_cdt_we = $urandom_range(0, 1) == 1;
            bus.ex_bubble = ($urandom_range(0, 7) == 0);
            bus.m_kill    = ($urandom_range(0, 7) == 0);
            bus.mem_rdata = $urandom;
            bus.rs_a      = 5'($urandom_range(0, 7));
            bus.rt_a      = 5'($urandom_range(0, 7));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
